// File: rtl/maxnet_frame_loader.sv
// rtl/maxnet_frame_loader.sv - Maxnet feed side: loads a 4-word frame, kicks the datapath, returns its maximum
module maxnet_frame_loader #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [1:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              start,
    input  logic              done,
    input  logic [DATA_W-1:0] max_in,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    input  logic              res_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_FILL,
        S_START,
        S_WAIT,
        S_RESULT
    } state_t;

    localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYC);

    state_t      state;
    logic [1:0]  count;
    logic [15:0] wd;
    logic [16:0] wd_inc;
    logic        accept;

    assign accept    = in_valid & in_ready;
    assign mem_we    = accept;
    assign mem_addr  = count;
    assign mem_wdata = accept ? in_data : '0;
    assign wd_inc    = {1'b0, wd} + 17'd1;

    // wd == 0 marks the first WAIT cycle, where a done level left over from the last frame is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FILL;
            count     <= 2'd0;
            wd        <= 16'd0;
            in_ready  <= 1'b1;
            start     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept) begin
                        if (count == 2'd3) begin
                            count    <= 2'd0;
                            state    <= S_START;
                            start    <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            count <= count + 2'd1;
                        end
                    end
                end
                S_START: begin
                    start <= 1'b0;
                    wd    <= 16'd0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    wd <= wd_inc[15:0];
                    if (wd != 16'd0 && done) begin
                        res_data  <= max_in;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= S_RESULT;
                    end else if (wd_inc == TIMEOUT_LIM) begin
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_FILL;
                    end
                end
                default: begin
                    state    <= S_FILL;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_frame_loader.sv
// tb/tb_maxnet_frame_loader.sv - randomized self-checking bench for maxnet_frame_loader
module tb_maxnet_frame_loader;

    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_we;
    logic [1:0]    mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          start;
    logic          done;
    logic [DW-1:0] max_in;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_err;
    logic          res_ready;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;
    int exp_starts = 0;
    logic [DW-1:0] fw [4];

    maxnet_frame_loader #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .start(start), .done(done), .max_in(max_in),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (start === 1'b1) start_cnt++;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_max();
        logic signed [DW-1:0] m;
        m = fw[0];
        for (int i = 1; i < 4; i++) if ($signed(fw[i]) > m) m = fw[i];
        return m;
    endfunction

    // Feed words fw[0..n-1]; random idle cycles unless gaps == 0
    task automatic feed_words(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int tries = 0;
            do begin
                @(posedge clk); #1;
                in_valid = !gaps || tries >= 5 || ($urandom_range(0, 2) != 0);
                in_data  = in_valid ? fw[i] : $urandom;
                tries++;
                @(negedge clk);
                check_eq("fill_in_ready", in_ready, 1);
                check_eq("fill_busy", busy, 0);
                check_eq("fill_mem_we", mem_we, in_valid);
                if (in_valid) begin
                    check_eq("fill_addr", mem_addr, i[1:0]);
                    check_eq("fill_wdata", mem_wdata, fw[i]);
                end
            end while (!in_valid);
        end
    endtask

    // done_at: first WAIT cycle (1-based) with done high; stale drives done high through START and WAIT cycle 1
    task automatic run_frame(input bit gaps, input int done_at, input bit stale, input int bp);
        int kc, exp_k;
        logic [DW-1:0] exp_data;
        logic exp_err;
        kc = (done_at < 2) ? 2 : done_at;
        if (kc <= TO) begin
            exp_k = kc; exp_err = 1'b0; exp_data = model_max();
        end else begin
            exp_k = TO; exp_err = 1'b1; exp_data = '0;
        end
        feed_words(4, gaps);
        exp_starts++;
        @(posedge clk); #1;
        in_valid = $urandom_range(0, 1);
        in_data  = $urandom;
        done     = stale;
        @(negedge clk);
        check_eq("start_pulse", start, 1);
        check_eq("start_in_ready", in_ready, 0);
        check_eq("start_mem_we", mem_we, 0);
        check_eq("start_busy", busy, 1);
        for (int k = 1; k <= exp_k; k++) begin
            @(posedge clk); #1;
            in_valid = $urandom_range(0, 1);
            done     = (k == 1 && stale) ? 1'b1 : (k >= done_at);
            max_in   = model_max();
            @(negedge clk);
            check_eq("wait_start_low", start, 0);
            check_eq("wait_res_valid", res_valid, 0);
            check_eq("wait_in_ready", in_ready, 0);
            check_eq("wait_mem_we", mem_we, 0);
        end
        for (int c = 0; c <= bp; c++) begin
            @(posedge clk); #1;
            res_ready = (c == bp);
            max_in    = $urandom;
            done      = $urandom_range(0, 1);
            @(negedge clk);
            check_eq("res_valid", res_valid, 1);
            check_eq("res_data", res_data, exp_data);
            check_eq("res_err", res_err, exp_err);
            check_eq("res_in_ready", in_ready, 0);
            check_eq("res_busy", busy, 1);
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        done      = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check_eq("post_res_valid", res_valid, 0);
        check_eq("post_in_ready", in_ready, 1);
        check_eq("post_busy", busy, 0);
        check_eq("start_count", start_cnt, exp_starts);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; done = 1'b0;
        max_in = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_start", start, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_data", res_data, 0);
        check_eq("rst_res_err", res_err, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b1;

        fw[0] = 5; fw[1] = 17; fw[2] = 9; fw[3] = 3;
        run_frame(1'b0, 6, 1'b0, 10);
        check_eq("frame1_max_model", model_max(), 17);

        fw[0] = 32'hFFFF_FFF0; fw[1] = 32'hFFFF_FFFE; fw[2] = 32'h8000_0000; fw[3] = 32'hFFFF_FFFF;
        run_frame(1'b1, 1, 1'b1, 2);

        fw[0] = 1; fw[1] = 2; fw[2] = 3; fw[3] = 4;
        run_frame(1'b1, 100, 1'b0, 3);
        run_frame(1'b0, TO, 1'b1, 0);

        fw[0] = $urandom; fw[1] = $urandom;
        feed_words(2, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_addr", mem_addr, 0);
        @(negedge clk);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_start", start, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        fw[0] = 1; fw[1] = 2; fw[2] = 3; fw[3] = 4;
        run_frame(1'b0, 3, 1'b0, 1);

        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < 4; i++) fw[i] = $urandom;
            run_frame(1'b1, $urandom_range(0, TO + 3), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
